// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO between a UART receiver and its consumer, first-word-fall-through.
// Optional per-entry frame-error flag is enabled by defining UART_RX_FIFO_FRAME_ERR_EN.
module uart_rx_fifo #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     wr_valid,
`ifdef UART_RX_FIFO_FRAME_ERR_EN
  input  logic                     wr_frame_err,
  output logic                     rd_frame_err,
`endif
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overrun,
  input  logic                     overrun_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef UART_RX_FIFO_FRAME_ERR_EN
  localparam int EW = DATA_WIDTH + 1;
`else
  localparam int EW = DATA_WIDTH;
`endif
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overrun;

  logic          w_push;
  logic          w_pop;
  logic          w_drop;
  logic          w_full;
  logic          w_empty;
  logic [EW-1:0] w_wr_entry;
  logic [EW-1:0] w_rd_entry;

  // Handshake: a byte transfers out when rd_valid && rd_ready at a rising edge;
  // the write side has no backpressure, so a strobe into a full FIFO without a
  // simultaneous pop is dropped and recorded in the sticky overrun flag.
  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty && rd_ready;
  assign w_push  = wr_valid && (!w_full || w_pop);
  assign w_drop  = wr_valid && w_full && !w_pop;

`ifdef UART_RX_FIFO_FRAME_ERR_EN
  assign w_wr_entry   = {wr_frame_err, wr_data};
  assign rd_frame_err = w_rd_entry[DATA_WIDTH];
`else
  assign w_wr_entry   = wr_data;
`endif

  assign w_rd_entry = r_mem[r_rd_ptr];
  assign rd_data    = w_rd_entry[DATA_WIDTH-1:0];
  assign rd_valid   = !w_empty;
  assign count      = r_count;
  assign full       = w_full;
  assign empty      = w_empty;
  assign overrun    = r_overrun;

  // Storage carries no reset; validity is tracked entirely by the count.
  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      r_mem[r_wr_ptr] <= w_wr_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (overrun_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a queue-based reference model tracks stored
// bytes and the overrun flag; scenario tasks compare DUT outputs against it.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int DW    = 8;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] wr_data;
  logic          wr_valid;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [4:0]    count;
  logic          full;
  logic          empty;
  logic          overrun;
  logic          overrun_clr;
  logic          wr_frame_err;
  logic          rd_frame_err;

  uart_rx_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
`ifdef UART_RX_FIFO_FRAME_ERR_EN
    .wr_frame_err(wr_frame_err),
    .rd_frame_err(rd_frame_err),
`endif
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

`ifndef UART_RX_FIFO_FRAME_ERR_EN
  assign rd_frame_err = 1'b0;
`endif

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model and scoreboard; bit DW holds the frame-error flag
  logic [DW:0] model_q[$];
  bit          model_ovr;
  logic [DW:0] exp_q[$];
  logic [DW:0] act_q[$];
  int          errors;
  int          checks;

  // driver: one clock of stimulus, model advanced from the pre-edge state
  task automatic cycle(input bit wv, input logic [DW-1:0] wd, input bit rr,
                       input bit oc, input bit fe);
    bit pop;
    bit push;
    wr_valid     = wv;
    wr_data      = wd;
    rd_ready     = rr;
    overrun_clr  = oc;
    wr_frame_err = fe;
    pop  = rr && (model_q.size() > 0);
    push = wv && ((model_q.size() < DEPTH) || pop);
    if (pop) begin
      exp_q.push_back(model_q.pop_front());
      act_q.push_back({rd_frame_err, rd_data});
    end
    if (push) model_q.push_back({fe, wd});
    if (wv && !push) model_ovr = 1'b1;
    else if (oc) model_ovr = 1'b0;
    @(posedge clk);
    #1;
    wr_valid     = 1'b0;
    rd_ready     = 1'b0;
    overrun_clr  = 1'b0;
    wr_frame_err = 1'b0;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    wr_valid = 1'b1;
    wr_data  = 8'hEE;
    rd_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    model_q.delete();
    exp_q.delete();
    act_q.delete();
    model_ovr = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_first_push();
    do_reset();
    cycle(1, 8'h41, 1, 0, 0);  // rd_ready while empty must not pop
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL first_rd_valid: got %b want 1", rd_valid); end
    checks++; if (rd_data !== 8'h41) begin errors++; $display("FAIL first_rd_data: got %h want 41", rd_data); end
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL first_count: got %0d want 1", count); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL first_empty: got %b want 0", empty); end
    cycle(0, 8'h00, 0, 0, 0);
    checks++; if (rd_data !== 8'h41) begin errors++; $display("FAIL hold_rd_data: got %h want 41", rd_data); end
    cycle(0, 8'h00, 1, 0, 0);
    checks++; if (act_q[0] !== exp_q[0]) begin errors++; $display("FAIL first_pop: got %h want %h", act_q[0], exp_q[0]); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL first_drained: got empty=%b want 1", empty); end
  endtask

  task automatic test_fill_overrun();
    do_reset();
    for (int i = 1; i <= DEPTH; i++) cycle(1, 8'(i), 0, 0, 0);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b want 1", full); end
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL fill_count: got %0d want 16", count); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL fill_overrun: got %b want 0", overrun); end
    cycle(1, 8'hAA, 0, 0, 0);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL drop_overrun: got %b want 1", overrun); end
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL drop_count: got %0d want 16", count); end
    for (int i = 0; i < DEPTH; i++) cycle(0, 8'h00, 1, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (act_q[i][DW-1:0] !== 8'(i + 1)) begin
        errors++; $display("FAIL drain_order[%0d]: got %h want %h", i, act_q[i][DW-1:0], 8'(i + 1));
      end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b want 1", empty); end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1, 8'($urandom_range(0, 255)), 0, 0, 0);
    cycle(1, 8'h55, 1, 0, 0);
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL fullpp_count: got %0d want 16", count); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL fullpp_overrun: got %b want 0", overrun); end
    for (int i = 0; i < DEPTH; i++) cycle(0, 8'h00, 1, 0, 0);
    checks++; if (act_q.size() != DEPTH + 1) begin errors++; $display("FAIL fullpp_pops: got %0d want %0d", act_q.size(), DEPTH + 1); end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL fullpp_data[%0d]: got %h want %h", i, act_q[i], exp_q[i]); end
    end
    checks++; if (act_q[act_q.size()-1][DW-1:0] !== 8'h55) begin errors++; $display("FAIL fullpp_last: got %h want 55", act_q[act_q.size()-1][DW-1:0]); end
  endtask

  task automatic test_random();
    int pushed;
    int guard;
    bit wv;
    do_reset();
    pushed = 0;
    guard  = 0;
    while ((pushed < 40 || model_q.size() > 0) && guard < 2000) begin
      wv = (pushed < 40) && ($urandom_range(0, 2) != 0);
      cycle(wv, 8'($urandom_range(0, 255)), $urandom_range(0, 1) == 1, 0, 0);
      if (wv) pushed++;
      guard++;
      checks++; if (count !== 5'(model_q.size()) || count > 5'd16) begin errors++; $display("FAIL rand_count: got %0d want %0d", count, model_q.size()); end
      checks++; if (rd_valid !== (model_q.size() > 0)) begin errors++; $display("FAIL rand_rd_valid: got %b want %b", rd_valid, model_q.size() > 0); end
      checks++; if (overrun !== model_ovr) begin errors++; $display("FAIL rand_overrun: got %b want %b", overrun, model_ovr); end
      if (model_q.size() > 0) begin
        checks++; if (rd_data !== model_q[0][DW-1:0]) begin errors++; $display("FAIL rand_head: got %h want %h", rd_data, model_q[0][DW-1:0]); end
      end
    end
    checks++; if (guard >= 2000) begin errors++; $display("FAIL rand_timeout: got %0d cycles want <2000", guard); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_seq[%0d]: got %h want %h", i, act_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_overrun_clr();
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1, 8'(i), 0, 0, 0);
    cycle(1, 8'hAA, 0, 0, 0);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL clr_set: got %b want 1", overrun); end
    cycle(1, 8'hBB, 0, 1, 0);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL clr_set_wins: got %b want 1", overrun); end
    cycle(0, 8'h00, 0, 1, 0);
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL clr_alone: got %b want 0", overrun); end
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL clr_count: got %0d want 16", count); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) cycle(1, 8'(i), 0, 0, 0);
    for (int i = 0; i < DEPTH - 5; i++) cycle(0, 8'h00, 1, 0, 0);
    checks++; if (count !== 5'd5) begin errors++; $display("FAIL mid_pre_count: got %0d want 5", count); end
    do_reset();
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL mid_count: got %0d want 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mid_empty: got %b want 1", empty); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL mid_rd_valid: got %b want 0", rd_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL mid_overrun: got %b want 0", overrun); end
`ifdef UART_RX_FIFO_FRAME_ERR_EN
    cycle(1, 8'h7E, 0, 0, 1);
    cycle(1, 8'h33, 0, 0, 0);
    checks++; if (rd_frame_err !== 1'b1) begin errors++; $display("FAIL fe_flag: got %b want 1", rd_frame_err); end
    checks++; if (rd_data !== 8'h7E) begin errors++; $display("FAIL fe_data: got %h want 7e", rd_data); end
    cycle(0, 8'h00, 1, 0, 0);
    checks++; if (rd_frame_err !== 1'b0) begin errors++; $display("FAIL fe_next_flag: got %b want 0", rd_frame_err); end
    checks++; if (rd_data !== 8'h33) begin errors++; $display("FAIL fe_next_data: got %h want 33", rd_data); end
`endif
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    rst_n        = 1'b0;
    wr_valid     = 1'b0;
    wr_data      = '0;
    rd_ready     = 1'b0;
    overrun_clr  = 1'b0;
    wr_frame_err = 1'b0;
    model_ovr    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_first_push();
    test_fill_overrun();
    test_full_push_pop();
    test_random();
    test_overrun_clr();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning byte entries stored; power of two, 2..256.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning bits per received character.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port wr_data  input  DATA_WIDTH  byte from the upstream UART receiver.
REQ-006 SHALL have port wr_valid  input  1  one-cycle strobe; wr_data is valid this cycle.
REQ-007 SHALL have port rd_data  output  DATA_WIDTH  oldest stored byte (first-word-fall-through).
REQ-008 SHALL have port rd_valid  output  1  high when rd_data holds a stored byte.
REQ-009 SHALL have port rd_ready  input  1  consumer accepts rd_data this cycle.
REQ-010 SHALL have port count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-011 SHALL have port full  output  1  count == DEPTH.
REQ-012 SHALL have port empty  output  1  count == 0.
REQ-013 SHALL have port overrun  output  1  sticky flag: a byte was dropped.
REQ-014 SHALL have port overrun_clr  input  1  clears overrun.

Function
REQ-015 SHALL push when wr_valid=1 and (full=0 or a pop occurs the same cycle); entry written at write pointer, pointer increments.
REQ-016 SHALL pop when rd_valid=1 and rd_ready=1; read pointer increments.
REQ-017 SHALL drive rd_valid = !empty; rd_data = entry at read pointer; both derived from registers only, no combinational path from wr_* inputs.
REQ-018 SHALL make a pushed byte visible on rd_data/rd_valid the cycle after the push (latency 1).
REQ-019 SHALL hold rd_data stable while rd_valid=1 and rd_ready=0.
REQ-020 SHALL leave rd_data don't-care when rd_valid=0.
REQ-021 SHALL update count: +1 on push only, -1 on pop only, unchanged on push+pop or neither.
REQ-022 SHALL wrap both pointers modulo DEPTH without gaps.
REQ-023 SHALL drop wr_data when wr_valid=1, full=1 and no pop; set overrun next cycle; contents and count unchanged.
REQ-024 SHALL, when empty and wr_valid=1 with rd_ready=1, only push (no pop since rd_valid=0).
REQ-025 SHALL clear overrun on overrun_clr=1; if a drop occurs the same cycle, set wins.
REQ-026 SHALL ignore rd_ready while empty: no pointer or count change.

Reset
REQ-027 SHALL on rst_n=0 at clk edge set pointers, count, overrun to 0; empty=1, full=0, rd_valid=0.
REQ-028 SHALL discard all stored entries on reset mid-operation; a wr_valid coinciding with reset is ignored.
REQ-029 SHALL not require storage array reset.

Configuration
REQ-030 SHALL support macro UART_RX_FIFO_FRAME_ERR_EN.
REQ-031 With UART_RX_FIFO_FRAME_ERR_EN defined: SHALL add input wr_frame_err (1) and output rd_frame_err (1); the flag is stored per entry alongside wr_data and presented with the same timing as rd_data.
REQ-032 Without UART_RX_FIFO_FRAME_ERR_EN: ports wr_frame_err and rd_frame_err SHALL not exist; storage is DATA_WIDTH bits per entry.

Verification
REQ-033 Reset, then push 0x41 -> next cycle rd_valid=1, rd_data=0x41, count=1, empty=0.
REQ-034 Push 0x01..0x10 (DEPTH=16), rd_ready=0 -> full=1, count=16; push 0xAA -> overrun=1, count=16; pop all -> 0x01..0x10 in order, 0xAA never appears.
REQ-035 Full FIFO, wr_valid=1 (0x55) with rd_ready=1 same cycle -> count stays 16, overrun stays 0, 0x55 read last.
REQ-036 Push/pop 40 bytes with random rd_ready -> output sequence equals input sequence across pointer wrap; count never exceeds 16.
REQ-037 Overrun set; overrun_clr=1 same cycle as another drop -> overrun=1; overrun_clr alone next -> overrun=0.
REQ-038 Count=5, assert rst_n=0 one cycle -> count=0, empty=1, rd_valid=0, overrun=0; with UART_RX_FIFO_FRAME_ERR_EN, push 0x7E with wr_frame_err=1 -> rd_frame_err=1 with rd_data=0x7E.
